// File: rtl/fifo_periph_pkg.sv
// rtl/fifo_periph_pkg.sv - register map and status bit layout shared by the FIFO peripheral
package fifo_periph_pkg;

    // Register byte offsets (full 4-bit decode)
    localparam logic [3:0] FSR_ADDR = 4'h0;
    localparam logic [3:0] FWD_ADDR = 4'h4;
    localparam logic [3:0] FRD_ADDR = 4'h8;

    // FSR bit positions
    localparam int EMPTY_BIT = 0;
    localparam int FULL_BIT  = 1;
    localparam int LEVEL_LSB = 2;

    // Bus data width of the register interface
    localparam int BUS_W = 32;

endpackage

// File: rtl/fifo_periph_fifo.sv
// rtl/fifo_periph_fifo.sv - circular byte buffer with wrap-bit pointers; level output built only with FIFO_PERIPH_LEVEL_EN
module fifo_periph_fifo #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = AW + 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_push,
    input  logic              i_pop,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata,
    output logic              o_empty,
`ifdef FIFO_PERIPH_LEVEL_EN
    output logic [LW-1:0]     o_level,
`endif
    output logic              o_full
);

    // Storage is deliberately left unreset; only the pointers define validity
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [LW-1:0]     r_wptr;
    logic [LW-1:0]     r_rptr;
    logic              w_empty;
    logic              w_full;
    logic              w_do_push;
    logic              w_do_pop;

    assign w_empty   = (r_wptr == r_rptr);
    assign w_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_do_push = i_push && !w_full;
    assign w_do_pop  = i_pop && !w_empty;

    assign o_empty = w_empty;
    assign o_full  = w_full;
    assign o_rdata = r_mem[r_rptr[AW-1:0]];

`ifdef FIFO_PERIPH_LEVEL_EN
    // The extra wrap bit makes the plain difference the occupancy, 0..DEPTH
    assign o_level = r_wptr - r_rptr;
`endif

    // Write the byte into the slot addressed by the low write-pointer bits
    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wptr[AW-1:0]] <= i_wdata;
        end
    end

    // Advance pointers modulo 2*DEPTH; a push on full or a pop on empty is a no-op
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_periph.sv
// rtl/fifo_periph.sv - APB FIFO peripheral (FSR/FWD/FRD), one wait state; FIFO_PERIPH_LEVEL_EN adds level in FSR
module fifo_periph
    import fifo_periph_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 8
) (
    input  logic             PCLK,
    input  logic             PRESET,
    input  logic [3:0]       PADDR,
    input  logic [BUS_W-1:0] PWDATA,
    input  logic             PWRITE,
    input  logic             PENABLE,
    input  logic             PSEL,
    output logic [BUS_W-1:0] PRDATA,
    output logic             PREADY
);

    localparam int LW = $clog2(DEPTH) + 1;

    logic             r_pready;
    logic [BUS_W-1:0] r_prdata;
    logic             w_access;
    logic             w_push;
    logic             w_pop;
    logic [DATA_W-1:0] w_rdata;
    logic             w_empty;
    logic             w_full;
    logic [BUS_W-1:0] w_fsr;
    logic [BUS_W-1:0] w_rd_value;
    logic             w_unused_pwdata;

    // The first access cycle is the only one where PREADY is still low
    assign w_access = PSEL && PENABLE && !r_pready;
    assign w_push   = w_access && PWRITE && (PADDR == FWD_ADDR);
    assign w_pop    = w_access && !PWRITE && (PADDR == FRD_ADDR);

    // Upper write-data bits are not stored
    assign w_unused_pwdata = &{1'b0, PWDATA[BUS_W-1:DATA_W]};

`ifdef FIFO_PERIPH_LEVEL_EN
    logic [LW-1:0] w_level;
`endif

    fifo_periph_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_fifo (
        .i_clk   (PCLK),
        .i_rst   (PRESET),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_wdata (PWDATA[DATA_W-1:0]),
        .o_rdata (w_rdata),
        .o_empty (w_empty),
`ifdef FIFO_PERIPH_LEVEL_EN
        .o_level (w_level),
`endif
        .o_full  (w_full)
    );

    // Assemble the status word from the current FIFO flags
    always_comb begin
        w_fsr            = '0;
        w_fsr[EMPTY_BIT] = w_empty;
        w_fsr[FULL_BIT]  = w_full;
`ifdef FIFO_PERIPH_LEVEL_EN
        w_fsr[LEVEL_LSB +: LW] = w_level;
`endif
    end

    // Read mux: FRD returns the head byte (0 when empty), unmapped reads return 0
    always_comb begin
        w_rd_value = '0;
        case (PADDR)
            FSR_ADDR: w_rd_value = w_fsr;
            FRD_ADDR: w_rd_value = w_empty ? '0 : {{(BUS_W-DATA_W){1'b0}}, w_rdata};
            default:  w_rd_value = '0;
        endcase
    end

    // Complete each transfer with a single-cycle PREADY; PRDATA holds its last value otherwise
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            r_pready <= 1'b0;
            r_prdata <= '0;
        end else begin
            r_pready <= w_access;
            if (w_access && !PWRITE) begin
                r_prdata <= w_rd_value;
            end
        end
    end

    assign PREADY = r_pready;
    assign PRDATA = r_prdata;

endmodule

// File: tb/tb_fifo_periph.sv
// tb/tb_fifo_periph.sv - scoreboard bench for fifo_periph against a queue-based model
module tb_fifo_periph;

    localparam int DEPTH = 4;

    logic        PCLK = 1'b0;
    logic        PRESET;
    logic [3:0]  PADDR;
    logic [31:0] PWDATA;
    logic        PWRITE;
    logic        PENABLE;
    logic        PSEL;
    logic [31:0] PRDATA;
    logic        PREADY;

    int checks = 0;
    int errors = 0;

    logic [7:0]  model_q[$];
    logic        exp_chk_q[$];
    logic [31:0] exp_val_q[$];

    fifo_periph #(.DEPTH(DEPTH), .DATA_W(8)) dut (
        .PCLK    (PCLK),
        .PRESET  (PRESET),
        .PADDR   (PADDR),
        .PWDATA  (PWDATA),
        .PWRITE  (PWRITE),
        .PENABLE (PENABLE),
        .PSEL    (PSEL),
        .PRDATA  (PRDATA),
        .PREADY  (PREADY)
    );

    always #5 PCLK = ~PCLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model_fsr();
        logic [31:0] r;
        int n;
        n    = model_q.size();
        r    = 32'h0;
        r[0] = (n == 0);
        r[1] = (n == DEPTH);
`ifdef FIFO_PERIPH_LEVEL_EN
        r = r | (32'(n) << 2);
`endif
        return r;
    endfunction

    task automatic model_issue(input logic [3:0] addr, input logic wr, input logic [31:0] wdata);
        logic [31:0] exp;
        exp = 32'h0;
        if (wr) begin
            if (addr == 4'h4 && model_q.size() < DEPTH) model_q.push_back(wdata[7:0]);
            exp_chk_q.push_back(1'b0);
            exp_val_q.push_back(32'h0);
        end else begin
            if (addr == 4'h0) exp = model_fsr();
            else if (addr == 4'h8 && model_q.size() > 0) exp = {24'h0, model_q.pop_front()};
            exp_chk_q.push_back(1'b1);
            exp_val_q.push_back(exp);
        end
    endtask

    task automatic apb(input logic [3:0] addr, input logic wr, input logic [31:0] wdata);
        bit seen;
        @(posedge PCLK) #1;
        PSEL = 1'b1; PENABLE = 1'b0; PADDR = addr; PWRITE = wr; PWDATA = wdata;
        @(posedge PCLK) #1;
        PENABLE = 1'b1;
        check("pready_low_first_access", PREADY, 1'b0);
        model_issue(addr, wr, wdata);
        @(posedge PCLK) #1;
        check("pready_after_one_wait", PREADY, 1'b1);
        seen = PREADY;
        for (int i = 0; i < 4 && !seen; i++) begin
            @(posedge PCLK) #1;
            seen = PREADY;
        end
        if (!seen) check("pready_timeout", 32'h0, 32'h1);
        @(posedge PCLK) #1;
        PSEL = 1'b0; PENABLE = 1'b0;
        check("pready_single_cycle", PREADY, 1'b0);
    endtask

    // Scoreboard monitor: every PREADY cycle consumes one expectation
    initial begin
        forever begin
            @(negedge PCLK);
            if (!PRESET && PREADY) begin
                if (exp_val_q.size() == 0) begin
                    check("unexpected_pready", 32'h1, 32'h0);
                end else begin
                    logic        chk;
                    logic [31:0] val;
                    chk = exp_chk_q.pop_front();
                    val = exp_val_q.pop_front();
                    if (chk) check("prdata", PRDATA, val);
                end
            end
        end
    end

    initial begin
        logic [3:0]  addr;
        logic        wr;
        logic [31:0] wd;
        logic [3:0]  addr_tbl [5];
        PRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 4'h0; PWDATA = 32'h0;
        addr_tbl[0] = 4'h0; addr_tbl[1] = 4'h4; addr_tbl[2] = 4'h8; addr_tbl[3] = 4'hC; addr_tbl[4] = 4'h4;
        #12;
        check("reset_pready", PREADY, 1'b0);
        check("reset_prdata", PRDATA, 32'h0);
        @(negedge PCLK);
        PRESET = 1'b0;

        apb(4'h0, 1'b0, 32'h0);
        apb(4'h4, 1'b1, 32'hFFFF_FFAA);
        apb(4'h4, 1'b1, 32'h0000_00BB);
        apb(4'h8, 1'b0, 32'h0);
        apb(4'h8, 1'b0, 32'h0);
        apb(4'h0, 1'b0, 32'h0);

        // Fill, overflow and drain twice to cover pointer wrap
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 1; i <= 5; i++) apb(4'h4, 1'b1, 32'(i * 8'h11));
            apb(4'h0, 1'b0, 32'h0);
            for (int i = 0; i < 4; i++) apb(4'h8, 1'b0, 32'h0);
            apb(4'h0, 1'b0, 32'h0);
        end

        // Empty pop, ignored write to FRD, unmapped address
        apb(4'h8, 1'b0, 32'h0);
        apb(4'h8, 1'b1, 32'h77);
        apb(4'hC, 1'b1, 32'h66);
        apb(4'hC, 1'b0, 32'h0);
        apb(4'h0, 1'b0, 32'h0);

        // Three entries stored: FSR shows level when the feature is built
        for (int i = 0; i < 3; i++) apb(4'h4, 1'b1, 32'(8'hC0 + i));
        apb(4'h0, 1'b0, 32'h0);
        apb(4'h8, 1'b0, 32'h0);

        // Reset during the access phase of a FWD write with 2 entries stored
        @(posedge PCLK) #1;
        PSEL = 1'b1; PENABLE = 1'b0; PADDR = 4'h4; PWRITE = 1'b1; PWDATA = 32'h99;
        @(posedge PCLK) #1;
        PENABLE = 1'b1;
        #2 PRESET = 1'b1;
        #1 check("abort_pready_low", PREADY, 1'b0);
        model_q.delete();
        @(posedge PCLK) #1;
        PSEL = 1'b0; PENABLE = 1'b0;
        @(negedge PCLK);
        PRESET = 1'b0;
        apb(4'h0, 1'b0, 32'h0);

        // Randomised traffic against the model
        for (int n = 0; n < 300; n++) begin
            addr = addr_tbl[$urandom_range(0, 4)];
            if ($urandom_range(0, 9) == 0) addr = 4'($urandom);
            wr = 1'($urandom);
            wd = $urandom;
            apb(addr, wr, wd);
        end
        apb(4'h0, 1'b0, 32'h0);

        repeat (3) @(posedge PCLK);
        check("scoreboard_drained", 32'(exp_val_q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_periph.md
# fifo_periph

APB-slave FIFO peripheral: an 8-bit-wide, parameterised-depth circular FIFO exposed through three memory-mapped registers. Software pushes bytes by writing FWD, pops them by reading FRD, and polls status in FSR. It sits on the APB bus behind the system bridge, with one PSEL per instance.

## Interface
- DEPTH, 4, FIFO entries; power of two, ≥2
- DATA_W, 8, stored data width; bits above DATA_W are ignored on write and read as 0
- PCLK  in  1  bus clock; all state on rising edge
- PRESET  in  1  asynchronous, active-high reset
- PADDR  in  4  byte address of the register
- PWDATA  in  32  write data
- PWRITE  in  1  1 = write, 0 = read
- PENABLE  in  1  APB access phase
- PSEL  in  1  peripheral select
- PRDATA  out  32  read data, valid while PREADY=1
- PREADY  out  1  transfer-complete strobe, one cycle per transfer

## Operation
- Register map, full 4-bit decode:
  - 0x0 FSR, read-only: bit0 = empty, bit1 = full, other bits 0 except per Configuration.
  - 0x4 FWD, write-only: a write pushes PWDATA[7:0]. Reads return 0.
  - 0x8 FRD, read-only: a read returns the head byte in PRDATA[7:0] and pops it. Writes are ignored.
  - Any other address: reads return 0, writes are ignored. PREADY still completes the transfer.
- Push when full: data is dropped and the FIFO is unchanged.
- Pop when empty: PRDATA = 0, pointers are unchanged.
- Occupancy is tracked with (log2 DEPTH)+1-bit read/write pointers:
  - Empty when the pointers are equal.
  - Full when the MSBs differ and the remaining bits are equal.
  - Pointers wrap modulo 2·DEPTH.
- One APB transfer is in flight at a time, so a push and a pop never occur on the same edge.
- Storage contents are not reset. Only the pointers and outputs are reset.

## Timing
- APB protocol with exactly one wait state.
  - Setup cycle: PSEL=1, PENABLE=0.
  - First access cycle: PREADY=0.
  - On the edge ending the first access cycle: the side effect (push/pop) occurs, and PREADY←1 and PRDATA are registered.
  - Next cycle: PREADY=1 and the master samples the transfer.
  - PREADY returns to 0 on the following edge.
- PREADY is set only when PSEL & PENABLE & ~PREADY. It never stays high two consecutive cycles.
- PRDATA holds the popped byte for the PREADY cycle, then its value is don't-care. Hold behaviour: retain the last value.
- FSR reflects state after all prior completed transfers. A read issued right after a push sees the updated flags.
- Reset (asynchronous, any time including mid-transfer):
  - PREADY=0, PRDATA=0, pointers=0.
  - FSR reads 0b01.
  - An aborted transfer has no side effect unless its PREADY edge already occurred.

## Configuration
- FIFO_PERIPH_LEVEL_EN defined: FSR[2 +: log2(DEPTH)+1] = current occupancy count (0..DEPTH).
- FIFO_PERIPH_LEVEL_EN undefined: those bits read 0, and no count logic is built.

## Structure
- Package fifo_periph_pkg holds:
  - Register offsets FSR_ADDR=4'h0, FWD_ADDR=4'h4, FRD_ADDR=4'h8.
  - FSR bit indices EMPTY_BIT=0, FULL_BIT=1, LEVEL_LSB=2.
- Sub-module fifo_periph_fifo: circular buffer with push/pop/wdata inputs and rdata/empty/full/level outputs.
- The top level holds the APB decode and the PREADY/PRDATA registers.

## Test plan
- Reset, then read 0x0 → PRDATA=0x1 (empty=1, full=0). PREADY is high exactly one cycle, two cycles after setup.
- Write 0x4 ← 0xAA, then 0x4 ← 0xBB. Read 0x8 → 0xAA, read 0x8 → 0xBB, read 0x0 → 0x1.
- Write 0x11,0x22,0x33,0x44 → FSR=0x2. Write 0x55 → dropped. Four FRD reads → 0x11,0x22,0x33,0x44 (pointer wrap also covered on a second fill).
- Read 0x8 when empty → 0, FSR stays 0x1. Write 0x8 and read 0xC → no state change, reads return 0.
- Assert PRESET during the access phase of a FWD write with 2 entries stored → PREADY=0 immediately, FSR=0x1 after release.
- With FIFO_PERIPH_LEVEL_EN and 3 entries stored → FSR=0x0C (level=3 at bit 2).
